// File: rtl/maluma_dispatch.sv
// In-order command dispatcher for the mALUma FP ALU: buffers requests, issues
// one at a time, returns results on a ready/valid port and keeps sticky flags.
module maluma_dispatch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [31:0]                  cmd_a,
    input  logic [31:0]                  cmd_b,
    input  logic [2:0]                   cmd_op,
    input  logic                         cmd_mode,
    input  logic                         cmd_round,
    output logic                         alu_start,
    output logic [31:0]                  alu_op_a,
    output logic [31:0]                  alu_op_b,
    output logic [2:0]                   alu_op_code,
    output logic                         alu_mode_fp,
    output logic                         alu_round_mode,
    input  logic                         alu_valid_out,
    input  logic [31:0]                  alu_result,
    input  logic [4:0]                   alu_flags,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_result,
    output logic [4:0]                   rsp_flags,
    output logic [4:0]                   sticky_flags,
    input  logic                         clr_flags,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HP = 32'h0000_7E00;
    localparam logic [4:0]  FLAG_INVALID = 5'b01000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        mode;
        logic        rnd;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state;
    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_c;
    logic            pop_c;
    logic            cap_en_c;
    logic [4:0]      cap_flags_c;

    assign cmd_ready  = (count != CW'(DEPTH));
    assign push_c     = cmd_valid && cmd_ready;
    assign pop_c      = (state == IDLE) && (count != '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    // Command storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (!push_c && pop_c) count <= count - CW'(1);
        end
    end

    // Flags landing in the response register this cycle (local invalid or ALU capture).
    always_comb begin
        cap_en_c    = 1'b0;
        cap_flags_c = '0;
        if (pop_c && head.op[2]) begin
            cap_en_c    = 1'b1;
            cap_flags_c = FLAG_INVALID;
        end else if ((state == WAIT) && alu_valid_out) begin
            cap_en_c    = 1'b1;
            cap_flags_c = alu_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            alu_start      <= 1'b0;
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            sticky_flags   <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        alu_op_a       <= head.mode ? head.a : {16'h0, head.a[15:0]};
                        alu_op_b       <= head.mode ? head.b : {16'h0, head.b[15:0]};
                        alu_op_code    <= head.op;
                        alu_mode_fp    <= head.mode;
                        alu_round_mode <= head.rnd;
                        if (head.op[2]) begin
                            rsp_result <= head.mode ? QNAN_SP : QNAN_HP;
                            rsp_flags  <= FLAG_INVALID;
                            rsp_valid  <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            alu_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (alu_valid_out) begin
                        rsp_result <= alu_mode_fp ? alu_result : {16'h0, alu_result[15:0]};
                        rsp_flags  <= alu_flags;
                        rsp_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A clear coinciding with a capture keeps only the new flags.
            if (clr_flags) sticky_flags <= cap_en_c ? cap_flags_c : 5'b0;
            else if (cap_en_c) sticky_flags <= sticky_flags | cap_flags_c;
        end
    end

endmodule

// File: tb/tb_maluma_dispatch.sv
// Directed self-checking bench for maluma_dispatch with a small fixed-latency ALU model.
module tb_maluma_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic        cmd_mode = 1'b0;
    logic        cmd_round = 1'b0;
    logic        alu_start;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [2:0]  alu_op_code;
    logic        alu_mode_fp;
    logic        alu_round_mode;
    logic        alu_valid_out;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [4:0]  sticky_flags;
    logic        clr_flags = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int overlap_viol = 0;
    logic       pend;
    logic [2:0] lat_cnt;

    maluma_dispatch #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .cmd_mode(cmd_mode), .cmd_round(cmd_round),
        .alu_start(alu_start), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp),
        .alu_round_mode(alu_round_mode),
        .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .clr_flags(clr_flags),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: known vectors give real answers, anything else a^b.
    // Half-precision answers carry junk in the upper half on purpose.
    function automatic logic [36:0] fake_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic mode);
        if (mode && op == 3'd0 && a == 32'h4000_0000 && b == 32'h4040_0000)
            return {5'b00000, 32'h40A0_0000};
        if (!mode && op == 3'd3 && a[15:0] == 16'h4500 && b[15:0] == 16'h0000)
            return {5'b00100, 32'hDEAD_7C00};
        if (!mode && op == 3'd0 && a[15:0] == 16'h4200 && b[15:0] == 16'h4500)
            return {5'b00000, 32'hDEAD_4800};
        return {(op == 3'd2) ? 5'b10000 : 5'b00000, a ^ b};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend          <= 1'b0;
            lat_cnt       <= '0;
            alu_valid_out <= 1'b0;
            alu_result    <= '0;
            alu_flags     <= '0;
        end else begin
            alu_valid_out <= 1'b0;
            if (alu_start) begin
                start_cnt <= start_cnt + 1;
                if (pend || alu_valid_out) overlap_viol <= overlap_viol + 1;
                pend    <= 1'b1;
                lat_cnt <= 3'd3;
                {alu_flags, alu_result} <= fake_alu(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp);
            end else if (pend) begin
                if (lat_cnt == 3'd0) begin
                    alu_valid_out <= 1'b1;
                    pend          <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 3'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the push lands on the next accepting rising edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic mode);
        int t = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = mode; cmd_round = 1'b0;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_flags);
        int t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_res"}, rsp_result, exp_res);
        chk({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ba_a   [5] = '{32'h100, 32'h211, 32'h322, 32'h433, 32'h544};
        logic [31:0] ba_b   [5] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1004};
        logic [2:0]  ba_op  [5] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
        logic [31:0] ba_res [5] = '{32'h1100, 32'h1210, 32'h1320, 32'h1430, 32'h1540};
        logic [4:0]  ba_flg [5] = '{5'b0, 5'b10000, 5'b0, 5'b10000, 5'b0};
        logic [31:0] held;
        int s0;
        int seen;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-precision add with issue timing
        s0 = start_cnt;
        push(32'h4000_0000, 32'h4040_0000, 3'd0, 1'b1);
        chk("sp_count_after_push", 32'(fifo_count), 32'd1);
        chk("sp_start_before_pop", 32'(alu_start), 32'd0);
        @(negedge clk);
        chk("sp_start_after_pop", 32'(alu_start), 32'd1);
        chk("sp_count_after_pop", 32'(fifo_count), 32'd0);
        get_rsp("sp_add", 32'h40A0_0000, 5'b00000);
        chk("sp_start_pulses", 32'(start_cnt - s0), 32'd1);
        chk("sp_sticky", 32'(sticky_flags), 32'd0);

        // Backpressure: five accepted, sixth refused while full
        for (int i = 0; i < 5; i++) push(ba_a[i], ba_b[i], ba_op[i], 1'b1);
        chk("bp_count_full", 32'(fifo_count), 32'd4);
        chk("bp_ready_low", 32'(cmd_ready), 32'd0);
        cmd_a = 32'h600; cmd_b = 32'h1005; cmd_op = 3'd0; cmd_mode = 1'b1;
        cmd_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_sixth_ready", 32'(cmd_ready), 32'd0);
        chk("bp_sixth_count", 32'(fifo_count), 32'd4);
        cmd_valid = 1'b0;
        held = rsp_result;
        repeat (4) @(negedge clk);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_stable", rsp_result, held);
        for (int i = 0; i < 5; i++) get_rsp($sformatf("bp_rsp%0d", i), ba_res[i], ba_flg[i]);
        chk("bp_sticky", 32'(sticky_flags), 32'h10);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("bp_sticky_clr", 32'(sticky_flags), 32'd0);

        // Half-precision divide by zero, then clear sticky
        push(32'h0000_4500, 32'h0000_0000, 3'd3, 1'b0);
        get_rsp("hp_div0", 32'h0000_7C00, 5'b00100);
        chk("hp_div0_sticky", 32'(sticky_flags), 32'h04);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("hp_div0_sticky_clr", 32'(sticky_flags), 32'd0);
        chk("hp_div0_rsp_kept", 32'(rsp_flags), 32'h04);

        // Invalid op codes complete locally
        s0 = start_cnt;
        push(32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 1'b1);
        @(negedge clk);
        chk("inv_sp_valid_early", 32'(rsp_valid), 32'd1);
        get_rsp("inv_sp", 32'h7FC0_0000, 5'b01000);
        chk("inv_sp_sticky", 32'(sticky_flags), 32'h08);
        push(32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 1'b0);
        get_rsp("inv_hp", 32'h0000_7E00, 5'b01000);
        chk("inv_no_start", 32'(start_cnt - s0), 32'd0);

        // Half-precision operand and result masking
        push(32'hFFFF_4200, 32'hABCD_4500, 3'd0, 1'b0);
        @(negedge clk);
        chk("hp_op_a", alu_op_a, 32'h0000_4200);
        chk("hp_op_b", alu_op_b, 32'h0000_4500);
        get_rsp("hp_add", 32'h0000_4800, 5'b00000);

        // Reset while waiting on the ALU with commands queued
        push(32'h1, 32'h2, 3'd0, 1'b1);
        push(32'h3, 32'h4, 3'd0, 1'b1);
        push(32'h5, 32'h6, 3'd0, 1'b1);
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_fifo_count", 32'(fifo_count), 32'd0);
        chk("mid_busy_rst", 32'(busy), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_alu_op_a", alu_op_a, 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = start_cnt;
        seen = 0;
        rsp_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        chk("mid_no_rsp", 32'(seen), 32'd0);
        chk("mid_no_start", 32'(start_cnt - s0), 32'd0);
        chk("start_overlap", 32'(overlap_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
